// File: rtl/of_pkg.sv
// Shared types and constants for the operand-fetch / writeback controller.
package of_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    OUT   = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] rn;
    logic [ADDR_W-1:0] rm;
    logic [ADDR_W-1:0] rd;
    logic              wen;
  } fetch_req_t;

  // Zero register first, then same-cycle writeback bypass, then register file.
  function automatic logic [DATA_W-1:0] select_operand(
    input logic [ADDR_W-1:0] r,
    input logic              wb_valid,
    input logic [ADDR_W-1:0] wb_rd,
    input logic [DATA_W-1:0] wb_data,
    input logic [DATA_W-1:0] rf_data
  );
    if (r == ZERO_REG) return '0;
    if (wb_valid && (wb_rd == r)) return wb_data;
    return rf_data;
  endfunction

endpackage

// File: rtl/of_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set wins over clear.
module of_scoreboard
  import of_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_idx,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_idx,
  input  logic [ADDR_W-1:0]   query_a,
  input  logic [ADDR_W-1:0]   query_b,
  input  logic [ADDR_W-1:0]   query_c,
  output logic                busy_a,
  output logic                busy_b,
  output logic                busy_c,
  output logic [NUM_REGS-1:0] pending
);

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && (set_idx != ZERO_REG)) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
  end

  // OR-ing the set mask last lets the younger issuing instruction win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_mask) | set_mask;
  end

  assign busy_a = pending[query_a] && (query_a != ZERO_REG);
  assign busy_b = pending[query_b] && (query_b != ZERO_REG);
  assign busy_c = pending[query_c] && (query_c != ZERO_REG);

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch with RAW/WAW hazard stall, writeback bypass and execute handshake.
module operand_fetch
  import of_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  logic [ADDR_W-1:0]   dec_rn,
  input  logic [ADDR_W-1:0]   dec_rm,
  input  logic [ADDR_W-1:0]   dec_rd,
  input  logic                dec_wen,
  output logic [ADDR_W-1:0]   rf_rd_addr1,
  output logic [ADDR_W-1:0]   rf_rd_addr2,
  input  logic [DATA_W-1:0]   rf_rd_data1,
  input  logic [DATA_W-1:0]   rf_rd_data2,
  output logic [ADDR_W-1:0]   rf_wr_addr,
  output logic [DATA_W-1:0]   rf_wr_data,
  output logic                rf_wr_en,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [DATA_W-1:0]   ex_op1,
  output logic [DATA_W-1:0]   ex_op2,
  output logic [ADDR_W-1:0]   ex_rd,
  output logic                ex_wen,
  output logic [31:0]         stall_cnt,
  output state_t              state,
  output logic [NUM_REGS-1:0] sb_pending
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and the offered payload holds until the transfer.

  state_t     state_next;
  fetch_req_t req;
  logic       latch_en;
  logic       issue;
  logic       stall;
  logic       busy_rn, busy_rm, busy_rd;
  logic       rn_clr, rm_clr, rd_clr;

  assign rf_rd_addr1 = req.rn;
  assign rf_rd_addr2 = req.rm;

  assign rf_wr_addr = wb_rd;
  assign rf_wr_data = wb_data;
  assign rf_wr_en   = wb_valid && (wb_rd != ZERO_REG);

  of_scoreboard u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (issue && req.wen),
    .set_idx (req.rd),
    .clr_en  (wb_valid),
    .clr_idx (wb_rd),
    .query_a (req.rn),
    .query_b (req.rm),
    .query_c (req.rd),
    .busy_a  (busy_rn),
    .busy_b  (busy_rm),
    .busy_c  (busy_rd),
    .pending (sb_pending)
  );

  // A writeback landing this cycle resolves the hazard because the bypass covers it.
  assign rn_clr = !busy_rn || (wb_valid && (wb_rd == req.rn));
  assign rm_clr = !busy_rm || (wb_valid && (wb_rd == req.rm));
  assign rd_clr = !req.wen || !busy_rd || (wb_valid && (wb_rd == req.rd));

  always_comb begin
    state_next = state;
    dec_ready  = 1'b0;
    ex_valid   = 1'b0;
    latch_en   = 1'b0;
    issue      = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        dec_ready = 1'b1;
        if (dec_valid) begin
          latch_en   = 1'b1;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (rn_clr && rm_clr && rd_clr) begin
          issue      = 1'b1;
          state_next = OUT;
        end else begin
          stall = 1'b1;
        end
      end
      OUT: begin
        ex_valid  = 1'b1;
        dec_ready = ex_ready;
        if (ex_ready) begin
          if (dec_valid) begin
            latch_en   = 1'b1;
            state_next = CHECK;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req <= '0;
    end else if (latch_en) begin
      req <= '{rn: dec_rn, rm: dec_rm, rd: dec_rd, wen: dec_wen};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_op1 <= '0;
      ex_op2 <= '0;
      ex_rd  <= '0;
      ex_wen <= 1'b0;
    end else if (issue) begin
      ex_op1 <= select_operand(req.rn, wb_valid, wb_rd, wb_data, rf_rd_data1);
      ex_op2 <= select_operand(req.rm, wb_valid, wb_rd, wb_data, rf_rd_data2);
      ex_rd  <= req.rd;
      ex_wen <= req.wen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized bench for operand_fetch against a register-value / pending-set reference model.
module tb_operand_fetch;
  import of_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                dec_valid = 1'b0;
  logic                dec_ready;
  logic [ADDR_W-1:0]   dec_rn = '0, dec_rm = '0, dec_rd = '0;
  logic                dec_wen = 1'b0;
  logic [ADDR_W-1:0]   rf_rd_addr1, rf_rd_addr2;
  logic [DATA_W-1:0]   rf_rd_data1, rf_rd_data2;
  logic [ADDR_W-1:0]   rf_wr_addr;
  logic [DATA_W-1:0]   rf_wr_data;
  logic                rf_wr_en;
  logic                wb_valid = 1'b0;
  logic [ADDR_W-1:0]   wb_rd = '0;
  logic [DATA_W-1:0]   wb_data = '0;
  logic                ex_valid;
  logic                ex_ready = 1'b0;
  logic [DATA_W-1:0]   ex_op1, ex_op2;
  logic [ADDR_W-1:0]   ex_rd;
  logic                ex_wen;
  logic [31:0]         stall_cnt;
  state_t              state;
  logic [NUM_REGS-1:0] sb_pending;

  // clock / reset
  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rn(dec_rn), .dec_rm(dec_rm), .dec_rd(dec_rd), .dec_wen(dec_wen),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd), .ex_wen(ex_wen),
    .stall_cnt(stall_cnt), .state(state), .sb_pending(sb_pending)
  );

  // environment register file, written only through the DUT write port
  logic [DATA_W-1:0] rf_mem [NUM_REGS];
  always @(posedge clk) if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;
  assign rf_rd_data1 = rf_mem[rf_rd_addr1];
  assign rf_rd_data2 = rf_mem[rf_rd_addr2];

  // reference model: architectural values and the set of registers awaiting writeback
  logic [DATA_W-1:0] arch [NUM_REGS];
  bit                pend [NUM_REGS];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_op1, exp_op2;
  logic [ADDR_W-1:0] exp_rd;
  logic              exp_wen;
  int unsigned       exp_stall;
  bit                in_out;
  int                checks = 0;
  int                errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pend_vec();
    logic [63:0] v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i] = pend[i];
    return v;
  endfunction

  function automatic bit blocked(input logic [ADDR_W-1:0] r);
    return (r != 5'd31) && pend[r] && !(wb_valid && (wb_rd == r));
  endfunction

  // one clock: check the write port, then commit this cycle's effects to the model
  task automatic tick(input bit capture, input logic [4:0] c_rn, input logic [4:0] c_rm,
                      input logic [4:0] c_rd, input logic c_wen);
    check("rf_wr_en", rf_wr_en, wb_valid && (wb_rd != 5'd31));
    if (wb_valid) begin
      check("rf_wr_addr", rf_wr_addr, wb_rd);
      check("rf_wr_data", rf_wr_data, wb_data);
    end
    @(posedge clk);
    if (wb_valid && (wb_rd != 5'd31)) arch[wb_rd] = wb_data;
    if (wb_valid) pend[wb_rd] = 1'b0;
    if (capture) begin
      exp_q.delete();
      exp_q.push_back(arch[c_rn]);
      exp_q.push_back(arch[c_rm]);
      exp_op1 = exp_q[0];
      exp_op2 = exp_q[1];
      exp_rd  = c_rd;
      exp_wen = c_wen;
      if (c_wen && (c_rd != 5'd31)) pend[c_rd] = 1'b1;
    end
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  task automatic rand_wb();
    logic [4:0] cand[$];
    for (int i = 0; i < 31; i++) if (pend[i]) cand.push_back(5'(i));
    wb_valid = 1'($urandom_range(0, 1));
    if (cand.size() > 0 && $urandom_range(0, 1) == 1)
      wb_rd = cand[$urandom_range(0, cand.size() - 1)];
    else
      wb_rd = 5'($urandom_range(0, 31));
    wb_data = {$urandom, $urandom};
  endtask

  task automatic check_out();
    check("ex_valid", ex_valid, 1'b1);
    check("ex_op1", ex_op1, exp_op1);
    check("ex_op2", ex_op2, exp_op2);
    check("ex_rd", ex_rd, exp_rd);
    check("ex_wen", ex_wen, exp_wen);
  endtask

  task automatic wb_only(input logic [4:0] r, input logic [63:0] d);
    ex_ready = 1'b0;
    dec_valid = 1'b0;
    wb_valid = 1'b1;
    wb_rd = r;
    wb_data = d;
    #1;
    if (in_out) check_out();
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic out_hold(input int n);
    for (int k = 0; k < n; k++) begin
      ex_ready = 1'b0;
      dec_valid = 1'($urandom_range(0, 1));
      dec_rn = 5'($urandom_range(0, 31));
      rand_wb();
      #1;
      check_out();
      check("dec_ready_hold", dec_ready, 1'b0);
      tick(0, 0, 0, 0, 0);
    end
  endtask

  // driver: deliver one instruction, resolve its hazards, and check what execute sees
  task automatic issue(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                       input logic wen, input int hold, input bit go_idle, input bit rnd,
                       input int limit, input logic [63:0] fdata);
    bit stall;
    bit done = 1'b0;
    if (in_out) begin
      out_hold(hold);
      if (go_idle) begin
        ex_ready = 1'b1;
        dec_valid = 1'b0;
        if (rnd) rand_wb();
        #1;
        check_out();
        check("dec_ready_out", dec_ready, 1'b1);
        tick(0, 0, 0, 0, 0);
        in_out = 1'b0;
      end
    end
    dec_valid = 1'b1;
    dec_rn = rn; dec_rm = rm; dec_rd = rd; dec_wen = wen;
    ex_ready = 1'b1;
    if (rnd) rand_wb();
    #1;
    check("dec_ready_accept", dec_ready, 1'b1);
    if (in_out) check_out();
    else        check("ex_valid_idle", ex_valid, 1'b0);
    tick(0, 0, 0, 0, 0);
    dec_valid = 1'b0;
    dec_rn = 5'($urandom_range(0, 31));
    dec_rd = 5'($urandom_range(0, 31));
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc < limit) begin
        if (rnd) rand_wb();
      end else begin
        if (rn != 5'd31 && pend[rn]) begin wb_valid = 1'b1; wb_rd = rn; wb_data = fdata; end
        else if (rm != 5'd31 && pend[rm]) begin wb_valid = 1'b1; wb_rd = rm; wb_data = fdata; end
        else if (wen && rd != 5'd31 && pend[rd]) begin wb_valid = 1'b1; wb_rd = rd; wb_data = fdata; end
      end
      stall = blocked(rn) || blocked(rm) || (wen && blocked(rd));
      #1;
      check("ex_valid_check", ex_valid, 1'b0);
      check("stall_cnt", stall_cnt, exp_stall);
      check("rf_rd_addr1", rf_rd_addr1, rn);
      check("rf_rd_addr2", rf_rd_addr2, rm);
      tick(!stall, rn, rm, rd, wen);
      if (stall) exp_stall++;
      else       done = 1'b1;
    end
    if (!done) check("issue_timeout", 1'b0, 1'b1);
    in_out = 1'b1;
    #1;
    check_out();
    check("sb", sb_pending, pend_vec());
    check("stall_cnt_end", stall_cnt, exp_stall);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) begin arch[i] = '0; pend[i] = 1'b0; end
    exp_stall = 0;
    in_out = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_ex_op1", ex_op1, 64'h0);
    check("rst_ex_op2", ex_op2, 64'h0);
    check("rst_ex_rd", ex_rd, 5'h0);
    check("rst_ex_wen", ex_wen, 1'b0);
    check("rst_stall_cnt", stall_cnt, 32'h0);
    check("rst_sb", sb_pending, 32'h0);
    check("rst_rd_addr1", rf_rd_addr1, 5'h0);
    check("rst_rd_addr2", rf_rd_addr2, 5'h0);
    check("rst_state", 64'(state), 64'(IDLE));
    check("rst_dec_ready", dec_ready, 1'b1);

    for (int i = 0; i < 31; i++) wb_only(5'(i), {$urandom, $urandom});
    wb_only(5'd1, 64'h10);
    wb_only(5'd2, 64'h20);

    // basic: X1 + X2 -> X3
    issue(5'd1, 5'd2, 5'd3, 1'b1, 0, 0, 0, 0, 64'h0);
    check("basic_op1", ex_op1, 64'h10);
    check("basic_op2", ex_op2, 64'h20);
    check("basic_sb3", sb_pending[3], 1'b1);
    // RAW on X3 for three cycles, then writeback bypass
    issue(5'd3, 5'd2, 5'd4, 1'b1, 0, 0, 0, 3, 64'hABCD);
    check("hazard_op1", ex_op1, 64'hABCD);
    check("hazard_stalls", stall_cnt, 32'd3);
    // zero register
    issue(5'd31, 5'd31, 5'd31, 1'b1, 2, 0, 0, 0, 64'h0);
    check("zero_op1", ex_op1, 64'h0);
    check("zero_op2", ex_op2, 64'h0);
    wb_only(5'd31, 64'h1234);
    // backpressure for five cycles, then back-to-back acceptance
    issue(5'd1, 5'd2, 5'd6, 1'b0, 0, 0, 0, 0, 64'h0);
    issue(5'd0, 5'd0, 5'd5, 1'b1, 5, 0, 0, 0, 64'h0);
    // WAW resolved by a same-cycle writeback; the new claim on X5 must survive
    issue(5'd6, 5'd7, 5'd5, 1'b1, 0, 0, 0, 0, 64'h5555);
    check("waw_sb5", sb_pending[5], 1'b1);

    for (int n = 0; n < 150; n++) begin
      issue(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1,
            $urandom_range(0, 4), {$urandom, $urandom});
    end

    // asynchronous reset while an instruction is presented to execute
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ex_valid", ex_valid, 1'b0);
    check("arst_sb", sb_pending, 32'h0);
    check("arst_stall_cnt", stall_cnt, 32'h0);
    check("arst_state", 64'(state), 64'(IDLE));
    check("arst_ex_op1", ex_op1, 64'h0);
    for (int i = 0; i < NUM_REGS; i++) pend[i] = 1'b0;
    exp_stall = 0;
    in_out = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(5'd1, 5'd2, 5'd3, 1'b1, 0, 0, 0, 0, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch and writeback controller that drives both ports of the 32×64 ARM register file. It takes decoded instructions from decode, looks up Rn/Rm, and resolves read-after-write and write-after-write hazards with a 32-entry scoreboard. It bypasses same-cycle writeback data and hands operands to execute over a valid/ready handshake. X31 always reads as zero and is never written.

## Interface
- DATA_W, 64, operand and writeback data width
- ADDR_W, 5, register index width
- ZERO_REG, 31, hard-wired zero register index
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- dec_valid / dec_ready  in / out  1 / 1  decode handshake
- dec_rn, dec_rm, dec_rd  in  ADDR_W  source and destination registers
- dec_wen  in  1  instruction writes dec_rd
- rf_rd_addr1, rf_rd_addr2  out  ADDR_W  register-file read addresses
- rf_rd_data1, rf_rd_data2  in  DATA_W  register-file read data (combinational, settles within one cycle)
- rf_wr_addr / rf_wr_data / rf_wr_en  out  ADDR_W / DATA_W / 1  register-file write port
- wb_valid  in  1  writeback from execute
- wb_rd  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback data
- ex_valid / ex_ready  out / in  1 / 1  execute handshake
- ex_op1, ex_op2  out  DATA_W  operands
- ex_rd  out  ADDR_W  destination register
- ex_wen  out  1  destination write enable
- stall_cnt  out  32  saturating count of hazard-stall cycles

## Operation
- FSM states: IDLE, CHECK, OUT.
- IDLE:
  - dec_ready=1.
  - On dec_valid, latch rn/rm/rd/wen and go to CHECK.
- CHECK:
  - rf_rd_addr1/2 are driven from latched rn/rm; they are always driven from the latch.
  - A source or destination r is clear when r==ZERO_REG, or sb[r]==0, or (wb_valid && wb_rd==r).
  - If rn, rm and (wen ? rd : none) are all clear: capture operands, set sb[rd] if wen && rd!=ZERO_REG, go to OUT.
  - Otherwise stay in CHECK and increment stall_cnt (saturating at 0xFFFF_FFFF).
- Operand select, per source, in priority order:
  1. r==ZERO_REG → 0.
  2. wb_valid && wb_rd==r → wb_data (bypass; the register file commits at the same edge).
  3. Otherwise → rf_rd_data.
- OUT:
  - ex_valid=1 with registered op1/op2/rd/wen.
  - On ex_ready: if dec_valid, latch the new instruction and go to CHECK; else go to IDLE.
  - dec_ready = ex_ready in this state (combinational).
- Writeback is pass-through combinational:
  - rf_wr_addr=wb_rd, rf_wr_data=wb_data.
  - rf_wr_en = wb_valid && wb_rd!=ZERO_REG.
  - sb[wb_rd] clears at the edge.
- Scoreboard set and clear of the same bit in one cycle: set wins, because the issuing instruction is younger.
- wb to a register whose sb bit is 0 is still written to the register file; the scoreboard is unchanged.

## Timing
- Reset values: state=IDLE, sb=0, ex_valid=0, ex_op1/op2=0, ex_rd=0, ex_wen=0, stall_cnt=0, latched fields=0 (so rf_rd_addr1/2=0).
- Latency, no hazard: decode handshake at edge N → CHECK in cycle N+1 → ex_valid in cycle N+2.
- Throughput: one instruction per 2 cycles with back-to-back OUT→CHECK.
- Each hazard cycle adds exactly one cycle. ex_valid asserts the cycle after the blocking wb_valid, because the bypass covers that cycle.
- ex_op*/ex_rd/ex_wen hold stable while ex_valid && !ex_ready.
- rst_n deasserted mid-operation: the in-flight instruction is dropped, scoreboard cleared, outputs return to reset values asynchronously.

## Structure
- Package of_pkg holds:
  - state enum {IDLE, CHECK, OUT};
  - ZERO_REG, DATA_W, ADDR_W constants;
  - a fetch-request struct {rn, rm, rd, wen}.
- Sub-module of_scoreboard: 32-bit pending vector, set/clear ports, set-wins priority, busy query for three indices, ZERO_REG always not-busy.

## Test plan
- After reset, dec: rn=1, rm=2, rd=3, wen=1, with X1=0x10 and X2=0x20 preloaded via wb; ex_ready=1 → ex_valid at N+2 with op1=0x10, op2=0x20, rd=3, sb[3]=1.
- Hazard: X3 pending; dec rn=3 → stays in CHECK and stall_cnt increments each cycle. Then wb_valid, wb_rd=3, wb_data=0xABCD → the same cycle captures op1=0xABCD, rf_wr_en=1, ex_valid next cycle.
- Zero register: dec rn=31, rm=31, rd=31, wen=1 → op1=op2=0, sb unchanged. wb_rd=31 → rf_wr_en=0.
- Backpressure: ex_ready=0 for 5 cycles → outputs stable, dec_ready=0. Then ex_ready=1 with dec_valid=1 → next instruction accepted, CHECK the next cycle.
- WAW plus set-wins: sb[5]=1; dec rd=5, wen=1 concurrent with wb_rd=5 → issues and sb[5] remains 1.
- Async reset asserted while in OUT → ex_valid=0 immediately, sb=0, stall_cnt=0, state IDLE.
